// File: rtl/afu_csr_pkg.sv
// Shared definitions for the AFU MMIO CSR endpoint: CSR byte offsets, MMIO channel structs,
// MMIO length encodings and the read-pipeline stage record.
package afu_csr_pkg;

    localparam logic [15:0] CSR_DFH          = 16'h0000;
    localparam logic [15:0] CSR_ID_L         = 16'h0008;
    localparam logic [15:0] CSR_ID_H         = 16'h0010;
    localparam logic [15:0] CSR_RSVD0        = 16'h0018;
    localparam logic [15:0] CSR_RSVD1        = 16'h0020;
    localparam logic [15:0] CSR_SCRATCH      = 16'h0028;
    localparam logic [15:0] CSR_CTRL         = 16'h0030;
    localparam logic [15:0] CSR_STATUS       = 16'h0038;
    localparam logic [15:0] CSR_UNMAPPED_CNT = 16'h0040;

    // 64-bit register index: MMIO DWord address bits [15:1]
    typedef logic [14:0] t_csr_idx;

    typedef enum logic [1:0] {
        MMIO_LEN_4B  = 2'b00,
        MMIO_LEN_8B  = 2'b01,
        MMIO_LEN_64B = 2'b10
    } t_mmio_len;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic       valid;
        logic [8:0] tid;
        t_csr_idx   idx;
        logic [1:0] len;
        logic       hi;
    } t_rd_stage;

    function automatic t_csr_idx csr_idx(input logic [15:0] byte_off);
        return t_csr_idx'(byte_off >> 3);
    endfunction

endpackage

// File: rtl/afu_mmio_csr.sv
// AFU MMIO CSR endpoint: DFH/ID header, scratch, control and status registers with a
// fixed two-cycle read response. Define MMIO_UNMAPPED_CNT_EN to add the unmapped-access counter at 0x40.
module afu_mmio_csr
    import afu_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [63:0] CTRL_RST  = 64'h0
) (
    input  logic           afu_clk,
    input  logic           reset,
    input  t_if_ccip_c0_Rx cp2af_mmio_c0rx,
    output t_if_ccip_c2_Tx af2cp_c2tx,
    output logic [63:0]    ctrl_o,
    output logic           ctrl_wr_pulse,
    input  logic [63:0]    status_i
);

    localparam t_csr_idx IDX_DFH     = csr_idx(CSR_DFH);
    localparam t_csr_idx IDX_ID_L    = csr_idx(CSR_ID_L);
    localparam t_csr_idx IDX_ID_H    = csr_idx(CSR_ID_H);
    localparam t_csr_idx IDX_RSVD0   = csr_idx(CSR_RSVD0);
    localparam t_csr_idx IDX_RSVD1   = csr_idx(CSR_RSVD1);
    localparam t_csr_idx IDX_SCRATCH = csr_idx(CSR_SCRATCH);
    localparam t_csr_idx IDX_CTRL    = csr_idx(CSR_CTRL);
    localparam t_csr_idx IDX_STATUS  = csr_idx(CSR_STATUS);

    t_csr_idx         req_idx;
    logic [1:0]       req_len;
    logic [1:0]       wr_lane;
    logic [1:0][31:0] wdata_lane;
    logic             ctrl_hit;

    logic [63:0] scratch_reg, scratch_next;
    logic [63:0] ctrl_reg, ctrl_next;
    logic        ctrl_wr_pulse_reg;

    t_rd_stage      rd_stage_reg, rd_stage_next;
    t_if_ccip_c2_Tx c2_reg;
    logic [63:0]    reg_val;
    logic [63:0]    rsp_data;
    logic [31:0]    rsp_dw;

    assign req_idx = cp2af_mmio_c0rx.hdr.address[15:1];
    assign req_len = cp2af_mmio_c0rx.hdr.length;

    // Lane enables for the two 32-bit halves; 64B writes touch nothing
    always_comb begin
        wr_lane = 2'b00;
        if (cp2af_mmio_c0rx.mmioWrValid) begin
            if (req_len == MMIO_LEN_8B) begin
                wr_lane = 2'b11;
            end else if (req_len == MMIO_LEN_4B) begin
                wr_lane = cp2af_mmio_c0rx.hdr.address[0] ? 2'b10 : 2'b01;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        if (gi == 0) begin : g_lo
            assign wdata_lane[gi] = cp2af_mmio_c0rx.data[31:0];
        end else begin : g_hi
            // a 4B write to the upper dword carries its payload in data[31:0]
            assign wdata_lane[gi] = (req_len == MMIO_LEN_4B) ? cp2af_mmio_c0rx.data[31:0]
                                                            : cp2af_mmio_c0rx.data[63:32];
        end
        assign scratch_next[gi*32 +: 32] = (wr_lane[gi] && req_idx == IDX_SCRATCH) ?
                                           wdata_lane[gi] : scratch_reg[gi*32 +: 32];
        assign ctrl_next[gi*32 +: 32]    = (wr_lane[gi] && req_idx == IDX_CTRL) ?
                                           wdata_lane[gi] : ctrl_reg[gi*32 +: 32];
    end

    assign ctrl_hit = (|wr_lane) && (req_idx == IDX_CTRL);

    always_ff @(posedge afu_clk) begin
        if (reset) begin
            scratch_reg       <= '0;
            ctrl_reg          <= CTRL_RST;
            ctrl_wr_pulse_reg <= 1'b0;
        end else begin
            scratch_reg       <= scratch_next;
            ctrl_reg          <= ctrl_next;
            ctrl_wr_pulse_reg <= ctrl_hit;
        end
    end

`ifdef MMIO_UNMAPPED_CNT_EN
    localparam t_csr_idx IDX_CNT = csr_idx(CSR_UNMAPPED_CNT);

    logic [31:0] unmapped_cnt_reg, unmapped_cnt_next;
    logic        rd_unmapped, wr_unmapped;
    logic [32:0] cnt_sum;

    // Reads of the reserved words are mapped; any write outside the writable set counts
    always_comb begin
        rd_unmapped = cp2af_mmio_c0rx.mmioRdValid && (req_idx > IDX_CNT);
        wr_unmapped = cp2af_mmio_c0rx.mmioWrValid &&
                      !(req_idx == IDX_SCRATCH || req_idx == IDX_CTRL || req_idx == IDX_CNT);
        cnt_sum     = {1'b0, unmapped_cnt_reg} + {32'h0, rd_unmapped} + {32'h0, wr_unmapped};
        if (cp2af_mmio_c0rx.mmioWrValid && req_idx == IDX_CNT) begin
            unmapped_cnt_next = '0;
        end else if (cnt_sum[32]) begin
            unmapped_cnt_next = 32'hFFFF_FFFF;
        end else begin
            unmapped_cnt_next = cnt_sum[31:0];
        end
    end

    always_ff @(posedge afu_clk) begin
        if (reset) begin
            unmapped_cnt_reg <= '0;
        end else begin
            unmapped_cnt_reg <= unmapped_cnt_next;
        end
    end
`endif

    always_comb begin
        rd_stage_next       = '0;
        rd_stage_next.valid = cp2af_mmio_c0rx.mmioRdValid;
        rd_stage_next.tid   = cp2af_mmio_c0rx.hdr.tid;
        rd_stage_next.idx   = req_idx;
        rd_stage_next.len   = req_len;
        rd_stage_next.hi    = cp2af_mmio_c0rx.hdr.address[0];
    end

    // Decode happens one cycle after the request so a write in the request cycle is visible
    always_comb begin
        reg_val = 64'h0;
        case (rd_stage_reg.idx)
            IDX_DFH:              reg_val = DFH_VALUE;
            IDX_ID_L:             reg_val = AFU_ID_L;
            IDX_ID_H:             reg_val = AFU_ID_H;
            IDX_RSVD0, IDX_RSVD1: reg_val = 64'h0;
            IDX_SCRATCH:          reg_val = scratch_reg;
            IDX_CTRL:             reg_val = ctrl_reg;
            IDX_STATUS:           reg_val = status_i;
`ifdef MMIO_UNMAPPED_CNT_EN
            IDX_CNT:              reg_val = {32'h0, unmapped_cnt_reg};
`endif
            default:              reg_val = 64'h0;
        endcase
        rsp_dw   = rd_stage_reg.hi ? reg_val[63:32] : reg_val[31:0];
        rsp_data = 64'h0;
        if (rd_stage_reg.len == MMIO_LEN_8B) begin
            rsp_data = reg_val;
        end else if (rd_stage_reg.len == MMIO_LEN_4B) begin
            rsp_data = {rsp_dw, rsp_dw};
        end
    end

    always_ff @(posedge afu_clk) begin
        if (reset) begin
            rd_stage_reg <= '0;
            c2_reg       <= '0;
        end else begin
            rd_stage_reg       <= rd_stage_next;
            c2_reg.mmioRdValid <= rd_stage_reg.valid;
            if (rd_stage_reg.valid) begin
                c2_reg.hdr.tid <= rd_stage_reg.tid;
                c2_reg.data    <= rsp_data;
            end
        end
    end

    assign af2cp_c2tx    = c2_reg;
    assign ctrl_o        = ctrl_reg;
    assign ctrl_wr_pulse = ctrl_wr_pulse_reg;

endmodule

// File: tb/tb_afu_mmio_csr.sv
// Scoreboard bench for afu_mmio_csr: directed scenarios plus random MMIO traffic checked
// against a byte-offset register model; a single monitor process does every comparison.
module tb_afu_mmio_csr;
    import afu_csr_pkg::*;

    localparam logic [63:0] P_DFH      = 64'h1000_0000_0000_1000;
    localparam logic [63:0] P_ID_L     = 64'h9E1C_55A0_3B7D_0C11;
    localparam logic [63:0] P_ID_H     = 64'h4F2A_8D61_E0B3_7724;
    localparam logic [63:0] P_CTRL_RST = 64'h0000_0000_0000_00C3;
`ifdef MMIO_UNMAPPED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           afu_clk = 1'b0;
    logic           reset   = 1'b1;
    t_if_ccip_c0_Rx c0rx    = '0;
    t_if_ccip_c2_Tx c2tx;
    logic [63:0]    ctrl_o;
    logic           ctrl_wr_pulse;
    logic [63:0]    status_i = 64'h0;

    always #5 afu_clk = ~afu_clk;

    afu_mmio_csr #(
        .DFH_VALUE (P_DFH),
        .AFU_ID_L  (P_ID_L),
        .AFU_ID_H  (P_ID_H),
        .CTRL_RST  (P_CTRL_RST)
    ) dut (
        .afu_clk         (afu_clk),
        .reset           (reset),
        .cp2af_mmio_c0rx (c0rx),
        .af2cp_c2tx      (c2tx),
        .ctrl_o          (ctrl_o),
        .ctrl_wr_pulse   (ctrl_wr_pulse),
        .status_i        (status_i)
    );

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
        string       name;
    } t_exp;

    t_exp        exp_q[$];
    t_exp        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0, chk_reset = 0, flush_win = 0, done = 0;
    logic [63:0] m_scratch = 64'h0;
    logic [63:0] m_ctrl    = P_CTRL_RST;
    logic [31:0] m_cnt     = 32'h0;
    logic [63:0] exp_ctrl  = P_CTRL_RST;
    bit          exp_pulse = 0;

    always @(posedge afu_clk) cyc <= cyc + 1;

    // ---------------- reference model (byte-offset register map) ----------------
    function automatic logic [63:0] model_qword(input logic [17:0] qoff);
        logic [63:0] v;
        v = 64'h0;
        case (qoff)
            18'h00:  v = P_DFH;
            18'h08:  v = P_ID_L;
            18'h10:  v = P_ID_H;
            18'h28:  v = m_scratch;
            18'h30:  v = m_ctrl;
            18'h38:  v = status_i;
            18'h40:  v = CNT_EN ? {32'h0, m_cnt} : 64'h0;
            default: v = 64'h0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] addr, input logic [1:0] len);
        logic [17:0] off;
        logic [63:0] q;
        logic [31:0] dw;
        off = {addr, 2'b00};
        q   = model_qword({off[17:3], 3'b000});
        dw  = off[2] ? q[63:32] : q[31:0];
        if (len == MMIO_LEN_8B) return q;
        if (len == MMIO_LEN_4B) return {dw, dw};
        return 64'h0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input bit upper,
                                          input logic [1:0] len, input logic [63:0] d);
        if (len == MMIO_LEN_8B) return d;
        if (len == MMIO_LEN_4B) return upper ? {d[31:0], old[31:0]} : {old[63:32], d[31:0]};
        return old;
    endfunction

    task automatic model_apply(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [1:0] len, input logic [63:0] d);
        logic [17:0] off;
        logic [17:0] q;
        longint      sum;
        off = {addr, 2'b00};
        q   = {off[17:3], 3'b000};
        sum = longint'(m_cnt);
        exp_pulse = 0;
        if (wr) begin
            if (q == 18'h28) m_scratch = merge(m_scratch, off[2], len, d);
            if (q == 18'h30) begin
                m_ctrl    = merge(m_ctrl, off[2], len, d);
                exp_pulse = (len == MMIO_LEN_8B) || (len == MMIO_LEN_4B);
            end
            if (!(q == 18'h28 || q == 18'h30 || q == 18'h40)) sum++;
        end
        if (rd && q > 18'h40) sum++;
        if (wr && q == 18'h40) m_cnt = 32'h0;
        else if (sum > longint'(32'hFFFF_FFFF)) m_cnt = 32'hFFFF_FFFF;
        else m_cnt = 32'(sum);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rd, input bit wr, input logic [15:0] addr, input logic [1:0] len,
                        input logic [8:0] tid, input logic [63:0] d, input bit rst,
                        input bit expect_rsp, input string name);
        t_exp x;
        c0rx.mmioRdValid = rd;
        c0rx.mmioWrValid = wr;
        c0rx.hdr.address = addr;
        c0rx.hdr.length  = len;
        c0rx.hdr.tid     = tid;
        c0rx.data        = d;
        reset            = rst;
        if (rd && !rst && expect_rsp) begin
            x.tid  = tid;
            x.data = model_read(addr, len);
            x.due  = cyc + 2;
            x.name = name;
            exp_q.push_back(x);
        end
        @(posedge afu_clk);
        #1;
        if (rst) begin
            m_scratch = 64'h0;
            m_ctrl    = P_CTRL_RST;
            m_cnt     = 32'h0;
            exp_pulse = 0;
        end else begin
            model_apply(rd, wr, addr, len, d);
        end
        exp_ctrl         = m_ctrl;
        c0rx.mmioRdValid = 1'b0;
        c0rx.mmioWrValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 0, 0, "idle");
    endtask

    task automatic do_rd(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid,
                         input string name);
        step(1, 0, addr, len, tid, 64'h0, 0, 1, name);
    endtask

    task automatic do_wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] d);
        step(0, 1, addr, len, 9'h0, d, 0, 0, "wr");
    endtask

    initial begin
        status_i = 64'h1357_9BDF_2468_ACE0;
        step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 1, 0, "rst");
        step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 1, 0, "rst");
        chk_reset = 1;
        step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 1, 0, "rst");
        chk_reset = 0;
        mon_en = 1;
        idle(1);

        // header reads
        do_rd(16'h0000, MMIO_LEN_8B, 9'd1, "dfh");
        do_rd(16'h0002, MMIO_LEN_8B, 9'd2, "id_l");
        do_rd(16'h0004, MMIO_LEN_8B, 9'd3, "id_h");
        idle(3);

        // scratch write then upper-dword 4B read
        do_wr(16'h000A, MMIO_LEN_8B, 64'hDEAD_BEEF_0123_4567);
        do_rd(16'h000B, MMIO_LEN_4B, 9'd4, "scratch_4b_hi");
        do_rd(16'h000A, MMIO_LEN_4B, 9'd5, "scratch_4b_lo");
        do_rd(16'h0006, MMIO_LEN_8B, 9'd6, "rsvd_18");
        do_rd(16'h000A, MMIO_LEN_64B, 9'd7, "scratch_64b");
        idle(3);

        // 4B write to CTRL upper dword
        do_wr(16'h000D, MMIO_LEN_4B, 64'h0000_0000_A5A5_0000);
        do_rd(16'h000C, MMIO_LEN_8B, 9'd8, "ctrl_8b");
        do_wr(16'h000C, MMIO_LEN_64B, 64'hFFFF_FFFF_FFFF_FFFF);
        do_wr(16'h0000, MMIO_LEN_8B, 64'h1111_2222_3333_4444);
        do_rd(16'h0000, MMIO_LEN_8B, 9'd9, "dfh_after_ro_wr");
        idle(3);

        // back-to-back reads alternating STATUS and an unmapped offset
        for (int i = 0; i < 16; i++) begin
            do_rd((i % 2 == 0) ? 16'h000E : 16'h0040, MMIO_LEN_8B, 9'(i), "b2b");
        end
        idle(4);

        // reset the cycle after a read: the read is flushed
        flush_win = 1;
        step(1, 0, 16'h000A, MMIO_LEN_8B, 9'h1AA, 64'h0, 0, 0, "flushed");
        step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 1, 0, "rst");
        step(0, 0, 16'h0, MMIO_LEN_8B, 9'h0, 64'h0, 1, 0, "rst");
        idle(2);
        flush_win = 0;
        do_rd(16'h000A, MMIO_LEN_8B, 9'd20, "scratch_after_rst");
        do_rd(16'h000C, MMIO_LEN_8B, 9'd21, "ctrl_after_rst");
        idle(3);

        // unmapped-access counter (reads 0 when the counter is not built)
        do_rd(16'h0080, MMIO_LEN_8B, 9'd22, "unmapped_200");
        do_wr(16'h0080, MMIO_LEN_8B, 64'h55);
        do_rd(16'h0080, MMIO_LEN_4B, 9'd23, "unmapped_200");
        do_rd(16'h0010, MMIO_LEN_8B, 9'd24, "cnt_3");
        do_wr(16'h0010, MMIO_LEN_8B, 64'h0);
        do_rd(16'h0010, MMIO_LEN_8B, 9'd25, "cnt_cleared");
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [15:0] a;
            logic [1:0]  l;
            if (i % 80 == 79) begin
                idle(2);
                status_i = {$urandom, $urandom};
            end
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 19)) : 16'($urandom);
            l  = 2'($urandom_range(0, 2));
            if (op < 5) begin
                do_rd(a, l, 9'($urandom), "rnd_rd");
            end else if (op < 8) begin
                if (l == MMIO_LEN_64B && a[15:1] == 15'd6) l = MMIO_LEN_8B;
                do_wr(a, l, {$urandom, $urandom});
            end else begin
                idle(1);
            end
        end
        idle(5);
        done = 1;
        #100;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge afu_clk) begin
        if (chk_reset) begin
            chk("rst_rd_valid", 64'(c2tx.mmioRdValid), 64'h0);
            chk("rst_tid", 64'(c2tx.hdr.tid), 64'h0);
            chk("rst_data", c2tx.data, 64'h0);
            chk("rst_ctrl_o", ctrl_o, P_CTRL_RST);
            chk("rst_pulse", 64'(ctrl_wr_pulse), 64'h0);
        end
        if (mon_en && !reset) begin
            chk("ctrl_o", ctrl_o, exp_ctrl);
            chk("ctrl_wr_pulse", 64'(ctrl_wr_pulse), 64'(exp_pulse));
        end
        if (flush_win) chk("flush_no_rsp", 64'(c2tx.mmioRdValid), 64'h0);
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            checks++;
            errors++;
            $display("FAIL missing_rsp %s: got no response expected tid %0d by cycle %0d",
                     exp_q[0].name, exp_q[0].tid, exp_q[0].due);
            void'(exp_q.pop_front());
        end
        if (c2tx.mmioRdValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got tid %0d data %h expected no response",
                         c2tx.hdr.tid, c2tx.data);
            end else begin
                e = exp_q.pop_front();
                $display("rsp %s tid=%0d data=%h cycle=%0d", e.name, c2tx.hdr.tid, c2tx.data, cyc);
                chk({e.name, "_tid"}, 64'(c2tx.hdr.tid), 64'(e.tid));
                chk({e.name, "_data"}, c2tx.data, e.data);
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
        if (done) begin
            chk("drain_empty", 64'(exp_q.size()), 64'h0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
